// File: rtl/spi_alu_slave_sync_if.sv
// rtl/spi_alu_slave_sync_if.sv - SPI pin and ALU-side signal bundle for spi_alu_slave_sync
//
// Groups the SPI pins (CS, SLCK, MOSI, MISO) with the ALU-facing operand,
// operation and result fields plus the frame status strobes.
//   slave  modport : used by spi_alu_slave_sync (samples pins, drives fields)
//   master modport : used by whoever drives the pins and supplies resultado
interface spi_alu_slave_sync_if #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 2,
    parameter int RES_W  = 4
);
    logic              CS;
    logic              SLCK;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W-1:0] num1;
    logic [DATA_W-1:0] num2;
    logic [OP_W-1:0]   operacion;
    logic [RES_W-1:0]  resultado;
    logic              frame_valid;
    logic              LED_handshake;
    logic              hs_error;

    modport slave (
        input  CS, SLCK, MOSI, resultado,
        output MISO, num1, num2, operacion, frame_valid, LED_handshake, hs_error
    );

    modport master (
        output CS, SLCK, MOSI, resultado,
        input  MISO, num1, num2, operacion, frame_valid, LED_handshake, hs_error
    );
endinterface

// File: rtl/spi_alu_slave_sync.sv
// rtl/spi_alu_slave_sync.sv - oversampled SPI mode-0 slave feeding an ALU and returning its result
//
// Every SPI pin is resynchronised into clk; nothing is clocked by SLCK.
// Frame: HS_REQ byte in, HS_ACK byte out, num1, num2, operacion in, resultado out.
// Ports:
//   clk   : system clock, at least 8x SLCK
//   rst_n : asynchronous active-low reset
//   bus   : spi_alu_slave_sync_if slave modport
//           CS/SLCK/MOSI in, MISO out, num1/num2/operacion out (last complete frame),
//           resultado in, frame_valid/hs_error one-clk pulses, LED_handshake sticky
module spi_alu_slave_sync #(
    parameter int         DATA_W = 4,
    parameter int         OP_W   = 2,
    parameter int         RES_W  = 4,
    parameter logic [7:0] HS_REQ = 8'hAA,
    parameter logic [7:0] HS_ACK = 8'hBB
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_alu_slave_sync_if.slave    bus
);

    localparam int MAX_A  = (DATA_W > 8) ? DATA_W : 8;
    localparam int MAX_B  = (OP_W > MAX_A) ? OP_W : MAX_A;
    localparam int MAX_W  = (RES_W > MAX_B) ? RES_W : MAX_B;
    localparam int CNT_W  = $clog2(MAX_W + 1);
    // TX register must hold either the ack byte or the full result
    localparam int TX_W   = (RES_W > 8) ? RES_W : 8;

    localparam logic [CNT_W-1:0] LAST_8 = CNT_W'(7);
    localparam logic [CNT_W-1:0] LAST_D = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_O = CNT_W'(OP_W - 1);
    localparam logic [CNT_W-1:0] LAST_R = CNT_W'(RES_W - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HS,
        S_ACK,
        S_NUM1,
        S_NUM2,
        S_OPER,
        S_RESULT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q;
    logic [1:0]        cs_sync_q;
    logic [1:0]        mosi_sync_q;
    logic [2:0]        slck_sync_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [6:0]        hs_rx_q;
    logic [DATA_W-1:0] rx1_q;
    logic [DATA_W-1:0] rx2_q;
    logic [OP_W-1:0]   op_rx_q;
    logic [TX_W-1:0]   tx_q;
    logic              tx_loaded_q;
    logic [DATA_W-1:0] num1_q;
    logic [DATA_W-1:0] num2_q;
    logic [OP_W-1:0]   op_q;
    logic              frame_valid_q;
    logic              led_q;
    logic              hs_error_q;

    logic cs_s;
    logic mosi_s;
    logic slck_rise;
    logic slck_fall;

    assign cs_s      = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    // SLCK and MOSI share synchroniser depth, so MOSI is aligned with the strobe
    assign slck_rise =  slck_sync_q[1] & ~slck_sync_q[2];
    assign slck_fall = ~slck_sync_q[1] &  slck_sync_q[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cs_sync_q     <= '0;
            mosi_sync_q   <= '0;
            slck_sync_q   <= '0;
            bit_cnt_q     <= '0;
            hs_rx_q       <= '0;
            rx1_q         <= '0;
            rx2_q         <= '0;
            op_rx_q       <= '0;
            tx_q          <= '0;
            tx_loaded_q   <= 1'b0;
            num1_q        <= '0;
            num2_q        <= '0;
            op_q          <= '0;
            frame_valid_q <= 1'b0;
            led_q         <= 1'b0;
            hs_error_q    <= 1'b0;
        end else begin
            cs_sync_q     <= {cs_sync_q[0], bus.CS};
            mosi_sync_q   <= {mosi_sync_q[0], bus.MOSI};
            slck_sync_q   <= {slck_sync_q[1:0], bus.SLCK};
            frame_valid_q <= 1'b0;
            hs_error_q    <= 1'b0;

            // CS deassertion overrides everything, including a final OPER bit
            if (cs_s) begin
                state_q     <= S_IDLE;
                bit_cnt_q   <= '0;
                tx_q        <= '0;
                tx_loaded_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q   <= S_HS;
                        bit_cnt_q <= '0;
                        hs_rx_q   <= '0;
                        rx1_q     <= '0;
                        rx2_q     <= '0;
                        op_rx_q   <= '0;
                    end

                    S_HS: begin
                        if (slck_rise) begin
                            hs_rx_q <= {hs_rx_q[5:0], mosi_s};
                            if (bit_cnt_q == LAST_8) begin
                                bit_cnt_q <= '0;
                                if ({hs_rx_q, mosi_s} == HS_REQ) begin
                                    state_q     <= S_ACK;
                                    led_q       <= 1'b1;
                                    tx_q        <= '0;
                                    tx_loaded_q <= 1'b0;
                                end else begin
                                    state_q    <= S_ERROR;
                                    hs_error_q <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end

                    S_ACK: begin
                        // first fall in the phase loads, later falls shift
                        if (slck_fall) begin
                            if (!tx_loaded_q) begin
                                tx_q        <= TX_W'(HS_ACK) << (TX_W - 8);
                                tx_loaded_q <= 1'b1;
                            end else begin
                                tx_q <= {tx_q[TX_W-2:0], 1'b0};
                            end
                        end
                        if (slck_rise) begin
                            if (bit_cnt_q == LAST_8) begin
                                bit_cnt_q   <= '0;
                                state_q     <= S_NUM1;
                                tx_q        <= '0;
                                tx_loaded_q <= 1'b0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end

                    S_NUM1: begin
                        if (slck_rise) begin
                            rx1_q <= DATA_W'({rx1_q, mosi_s});
                            if (bit_cnt_q == LAST_D) begin
                                bit_cnt_q <= '0;
                                state_q   <= S_NUM2;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end

                    S_NUM2: begin
                        if (slck_rise) begin
                            rx2_q <= DATA_W'({rx2_q, mosi_s});
                            if (bit_cnt_q == LAST_D) begin
                                bit_cnt_q <= '0;
                                state_q   <= S_OPER;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end

                    S_OPER: begin
                        if (slck_rise) begin
                            op_rx_q <= OP_W'({op_rx_q, mosi_s});
                            if (bit_cnt_q == LAST_O) begin
                                // all three fields publish together
                                bit_cnt_q     <= '0;
                                num1_q        <= rx1_q;
                                num2_q        <= rx2_q;
                                op_q          <= OP_W'({op_rx_q, mosi_s});
                                frame_valid_q <= 1'b1;
                                state_q       <= S_RESULT;
                                tx_q          <= '0;
                                tx_loaded_q   <= 1'b0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end

                    S_RESULT: begin
                        // resultado is sampled on the first fall, well after the fields settled
                        if (slck_fall) begin
                            if (!tx_loaded_q) begin
                                tx_q        <= TX_W'(bus.resultado) << (TX_W - RES_W);
                                tx_loaded_q <= 1'b1;
                            end else begin
                                tx_q <= {tx_q[TX_W-2:0], 1'b0};
                            end
                        end
                        if (slck_rise) begin
                            if (bit_cnt_q == LAST_R) begin
                                bit_cnt_q   <= '0;
                                state_q     <= S_DONE;
                                tx_q        <= '0;
                                tx_loaded_q <= 1'b0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end

                    S_DONE, S_ERROR: begin
                        bit_cnt_q <= '0;
                    end

                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.MISO          = ((state_q == S_ACK) || (state_q == S_RESULT)) & tx_q[TX_W-1];
    assign bus.num1          = num1_q;
    assign bus.num2          = num2_q;
    assign bus.operacion     = op_q;
    assign bus.frame_valid   = frame_valid_q;
    assign bus.LED_handshake = led_q;
    assign bus.hs_error      = hs_error_q;

endmodule

// File: doc/spi_alu_slave_sync.md
# spi_alu_slave_sync

Parametrised SPI mode-0 slave that receives the handshake, operand and operation fields from the master, presents them to the ALU, and returns the ALU result over MISO within the same chip-select frame. All SPI pins are oversampled in the system clock domain (no logic clocked by SLCK). The block sits between the board SPI pins and the ALU datapath and replaces the single-clock SLCK-driven receiver.

## Interface
- DATA_W, 4: operand width (num1, num2), 1..16
- OP_W, 2: operation field width, 1..4
- RES_W, 4: result width returned on MISO, 1..16
- HS_REQ, 8'hAA: handshake byte expected from the master
- HS_ACK, 8'hBB: acknowledge byte returned to the master
- clk  in  1  system clock, must be ≥ 8× SLCK frequency
- rst_n  in  1  asynchronous, active-low reset
- CS  in  1  SPI chip select, active low, asynchronous to clk
- SLCK  in  1  SPI clock, asynchronous to clk
- MOSI  in  1  master-out data, MSB first
- MISO  out  1  slave-out data, MSB first
- num1  out  DATA_W  first operand, last completed frame
- num2  out  DATA_W  second operand, last completed frame
- operacion  out  OP_W  operation code, last completed frame
- resultado  in  RES_W  ALU result, combinational from num1/num2/operacion
- frame_valid  out  1  one-clk pulse when num1/num2/operacion update
- LED_handshake  out  1  sticky, set on accepted handshake
- hs_error  out  1  one-clk pulse on handshake mismatch

## Operation
- CS, SLCK, MOSI each pass through a 2-flop synchroniser; SLCK rise/fall detected from the 3rd flop vs. 2nd flop. MOSI is sampled on detected SLCK rise; MISO changes on detected SLCK fall.
- Reset: all outputs 0, state IDLE, counters 0, tx/rx shift registers 0.
- States and phase lengths (bits counted on SLCK rises):
  - IDLE: synchronised CS low → HANDSHAKE, bit counter 0.
  - HANDSHAKE (8 bits): shift MOSI in. On 8th bit: match HS_REQ → ACK, LED_handshake ← 1; otherwise → ERROR, hs_error pulse.
  - ACK (8 bits): MOSI ignored; MISO shifts HS_ACK. After 8th bit → NUM1.
  - NUM1 (DATA_W bits), NUM2 (DATA_W bits), OPER (OP_W bits): shift MOSI into private rx registers.
  - After last OPER bit: num1, num2, operacion load together from rx registers; frame_valid pulses the same clk; → RESULT.
  - RESULT (RES_W bits): MISO shifts captured result. After last bit → DONE.
  - DONE / ERROR: ignore SLCK, MISO = 0, wait for CS high → IDLE.
- TX register: loaded on the first SLCK fall after entering ACK (HS_ACK) or RESULT (resultado), shifted left on each later fall; MISO = tx MSB while in ACK/RESULT, else 0. resultado is therefore sampled ≥ 4 clk after frame_valid.
- Synchronised CS high in any state → IDLE next clk; partial fields discarded; num1/num2/operacion keep previous values; no frame_valid.
- Field widths set only by parameters; no truncation or extension across fields. Bit counter width = clog2(max(8, DATA_W, OP_W, RES_W)+1).
- LED_handshake clears only on reset.

## Timing
- Input-to-detect latency: 3 clk from pin edge to internal rise/fall strobe.
- MISO valid ≤ 4 clk after SLCK fall; requires SLCK half-period ≥ 4 clk.
- frame_valid: 3–4 clk after the pin rise of the last OPER bit; exactly 1 clk wide.
- CS high must be held ≥ 3 clk between frames; the first SLCK rise must be ≥ 4 clk after CS falls.
- Simultaneous CS rise and last-OPER-bit rise strobe in the same clk: CS wins, frame discarded.
- Extra SLCK edges in DONE/ERROR: no effect.

## Test plan
- Full frame, defaults: AA, ack byte, num1=4'h5, num2=4'h3, op=2'b01 → MISO byte 0xBB, frame_valid once, outputs 5/3/01, resultado=4'h8 returned as 1000 on MISO, LED_handshake=1.
- Bad handshake 0xA5 → hs_error pulse, LED_handshake stays 0, MISO=0 rest of frame, outputs unchanged.
- CS rises after 2 bits of NUM2 → state IDLE, no frame_valid, outputs hold previous frame; next frame completes normally.
- Params DATA_W=8, OP_W=3, RES_W=9: num1=8'hC3, num2=8'h1F, op=3'b110, resultado=9'h1A5 → outputs match, 9 bits 1_1010_0101 on MISO.
- rst_n low mid-RESULT → all outputs 0 immediately (async), MISO 0, IDLE after release; LED_handshake cleared.
- Two back-to-back frames with 3-clk CS gap, clk = 8× SLCK → both frames decoded, two frame_valid pulses.
